// File: rtl/enigma_return_path.sv
// Return pass of the I/II/III scrambler: reflected letter through the inverse
// wiring of rotors I, II, III, one rotor per pipeline stage, valid/ready handshake.
module enigma_return_path (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_letter,
    input  logic [4:0]  pos_l,
    input  logic [4:0]  pos_m,
    input  logic [4:0]  pos_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_letter,
    output logic        out_err,
    output logic [15:0] count
);

    localparam logic [4:0] INV_I [26] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
        5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
    localparam logic [4:0] INV_II [26] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
        5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
    localparam logic [4:0] INV_III [26] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
        5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

    function automatic logic [4:0] add_mod26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub_mod26(input logic [4:0] a, input logic [4:0] b);
        logic signed [6:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        if (d < 7'sd0) d = d + 7'sd26;
        return d[4:0];
    endfunction

    // Errored letters look up entry 0 so no table is ever indexed out of range.
    function automatic logic [4:0] rotor_step(input logic [1:0] rotor, input logic [4:0] y,
                                              input logic [4:0] p, input logic err);
        logic [4:0] idx;
        logic [4:0] w;
        idx = err ? 5'd0 : add_mod26(y, p);
        case (rotor)
            2'd0:    w = INV_I[idx];
            2'd1:    w = INV_II[idx];
            default: w = INV_III[idx];
        endcase
        return err ? 5'd0 : sub_mod26(w, p);
    endfunction

    logic       vld_p0, vld_p1, vld_p2;
    logic [4:0] let_p0, let_p1;
    logic       err_p0, err_p1;
    logic [4:0] posm_p0, posr_p0, posr_p1;
    logic       adv1, adv2, in_err;

    assign adv2      = !vld_p2 | out_ready;
    assign adv1      = !vld_p1 | adv2;
    assign in_ready  = !vld_p0 | adv1;
    assign out_valid = vld_p2;
    assign in_err    = (in_letter > 5'd25) | (pos_l > 5'd25) | (pos_m > 5'd25) | (pos_r > 5'd25);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            out_letter <= 5'd0;
            out_err    <= 1'b0;
            count      <= 16'd0;
        end else begin
            if (in_ready) vld_p0 <= in_valid;
            if (adv1)     vld_p1 <= vld_p0;
            if (adv2)     vld_p2 <= vld_p1;
            // Stage 3 boundary: rotor III inverse, output register
            if (adv2 && vld_p1) begin
                out_letter <= rotor_step(2'd2, let_p1, posr_p1, err_p1);
                out_err    <= err_p1;
            end
            if (vld_p2 && out_ready) count <= count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // Stage 1 boundary: rotor I inverse
        if (in_ready && in_valid) begin
            let_p0  <= rotor_step(2'd0, in_letter, pos_l, in_err);
            err_p0  <= in_err;
            posm_p0 <= pos_m;
            posr_p0 <= pos_r;
        end
        // Stage 2 boundary: rotor II inverse
        if (adv1 && vld_p0) begin
            let_p1  <= rotor_step(2'd1, let_p0, posm_p0, err_p0);
            err_p1  <= err_p0;
            posr_p1 <= posr_p0;
        end
    end

endmodule

// File: tb/tb_enigma_return_path.sv
// Self-checking bench for enigma_return_path: directed cases plus randomized
// streams scored against a letter-level model of the inverse rotor pass.
module tb_enigma_return_path;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_letter = 5'd0;
    logic [4:0]  pos_l = 5'd0;
    logic [4:0]  pos_m = 5'd0;
    logic [4:0]  pos_r = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_letter;
    logic        out_err;
    logic [15:0] count;

    int passed = 0;
    int total = 0;
    int exp_count = 0;
    int exp_q[$];

    enigma_return_path dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
        .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_letter(out_letter), .out_err(out_err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Inverse wiring written as letter strings, exactly as the rotor sheets list them.
    function automatic int inv_wire(input int rotor, input int idx);
        string s;
        case (rotor)
            0:       s = "UWYGADFPVZBECKMTHXSLRINQOJ";
            1:       s = "AJPCZWRLFBDKOTYUQGENHXMIVS";
            default: s = "TAGBPCSDQEUFVNZHYIXJWLRKOM";
        endcase
        return int'(s[idx]) - 65;
    endfunction

    function automatic int model(input int l, input int pl, input int pm, input int pr);
        int y;
        int p[3];
        if (l > 25 || pl > 25 || pm > 25 || pr > 25) return 32;  // err=1, letter=0
        p[0] = pl; p[1] = pm; p[2] = pr;
        y = l;
        for (int r = 0; r < 3; r++)
            y = (inv_wire(r, (y + p[r]) % 26) - p[r] + 26) % 26;
        return y;
    endfunction

    task automatic monitor();
        logic       hv;
        logic [4:0] hl;
        logic       he;
        int         e;
        hv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hv = 1'b0;
            end else begin
                if (hv) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_letter", out_letter, hl);
                    check("hold_err", out_err, he);
                end
                if (out_valid && out_ready) begin
                    check("unexpected_out", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("sb_letter", out_letter, e % 32);
                        check("sb_err", out_err, e / 32);
                        exp_count++;
                    end
                end
                hv = out_valid && !out_ready;
                hl = out_letter;
                he = out_err;
                if (in_valid && in_ready)
                    exp_q.push_back(model(in_letter, pos_l, pos_m, pos_r));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input int l, input int pl, input int pm, input int pr,
                          input int el, input int ee);
        int c0;
        c0 = exp_count;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_letter = 5'(l); pos_l = 5'(pl); pos_m = 5'(pm); pos_r = 5'(pr);
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_letter"}, out_letter, el);
        check({tag, "_err"}, out_err, ee);
        tick();
        check({tag, "_count"}, count, (c0 + 1) % 65536);
    endtask

    task automatic load(input int idx, input bit rnd);
        in_valid = 1'b1;
        if (rnd && $urandom_range(0, 9) == 0) in_letter = 5'($urandom_range(26, 31));
        else in_letter = rnd ? 5'($urandom_range(0, 25)) : 5'(idx);
        pos_l = 5'($urandom_range(0, 25));
        pos_m = 5'($urandom_range(0, 25));
        pos_r = 5'($urandom_range(0, 25));
        if (rnd && $urandom_range(0, 19) == 0) pos_m = 5'($urandom_range(26, 31));
    endtask

    task automatic stream(input string tag, input int n, input bit rnd, input int budget);
        int sent, k, start;
        bit xfer, saw_block;
        sent = 0; k = 0; start = exp_count; saw_block = 0;
        out_ready = 1'b1;
        load(0, rnd);
        while (sent < n && k < budget) begin
            @(negedge clk);
            xfer = in_valid && in_ready;
            if (!in_ready) saw_block = 1;
            tick();
            k++;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(k >= 5 && k <= 9);
            if (!rnd && k == 8) check({tag, "_stall_in_ready"}, in_ready, 0);
            if (xfer) begin
                sent++;
                if (sent >= n || (rnd && $urandom_range(0, 3) == 0)) in_valid = 1'b0;
                else load(sent, rnd);
            end else if (!in_valid) begin
                load(sent, rnd);
            end
        end
        in_valid = 1'b0;
        check({tag, "_sent"}, sent, n);
        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            tick();
            k++;
        end
        tick();
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_outputs"}, exp_count - start, n);
        check({tag, "_count"}, count, exp_count % 65536);
        if (!rnd) check({tag, "_blocked"}, saw_block, 1);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_letter", out_letter, 0);
        check("rst_out_err", out_err, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        // Directed single letters
        single("t1_a", 0, 0, 0, 0, 3, 0);
        single("t2_wrap", 0, 1, 0, 0, 10, 0);
        single("t3_idx24", 25, 25, 0, 0, 22, 0);
        single("t3_model", 25, 25, 0, 0, model(25, 25, 0, 0), 0);
        single("t5_err", 27, 0, 0, 0, 0, 1);
        single("t5_after", 0, 0, 0, 0, 3, 0);
        single("t5_poserr", 4, 3, 30, 2, 0, 1);
        single("t5_after2", 7, 9, 14, 21, model(7, 9, 14, 21), 0);

        // 26 letters back to back with a five-cycle output stall
        stream("t4", 26, 1'b0, 200);

        // Reset with two letters in flight
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_letter = 5'd1; pos_l = 5'd0; pos_m = 5'd0; pos_r = 5'd0;
        tick();
        in_letter = 5'd2;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_count", count, 0);
        exp_count = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_stale", out_valid, 0);
        end
        check("t6_count_after", count, 0);

        // Randomized traffic with random backpressure and occasional bad codes
        stream("rand", 60, 1'b1, 2000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
